// File: rtl/mem_access_unit.sv
// Load/store access unit: one outstanding request, lane alignment of store data and
// byte enables, load extraction with sign/zero extension, misalignment and timeout errors.
module mem_access_unit #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [1:0]  req_size_i,
   input  logic        req_signed_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] req_wdata_i,
   input  logic [4:0]  req_rd_i,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic [4:0]  rsp_rd_o,
   output logic [1:0]  rsp_err_o
);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);

   state_t      state;
   logic [7:0]  wait_cnt;
   logic        we_q;
   logic [1:0]  size_q;
   logic        signed_q;
   logic [1:0]  addr_q;
   logic [4:0]  rd_q;

   logic        misaligned;
   logic [3:0]  be_next;
   logic [31:0] wdata_next;
   logic [31:0] lane;
   logic [31:0] load_ext;

   always_comb begin
      misaligned = 1'b0;
      be_next    = 4'b1111;
      wdata_next = req_wdata_i;
      case (req_size_i)
         2'b00: begin
            be_next    = 4'b0001 << req_addr_i[1:0];
            wdata_next = {4{req_wdata_i[7:0]}};
         end
         2'b01: begin
            misaligned = req_addr_i[0];
            be_next    = 4'b0011 << req_addr_i[1:0];
            wdata_next = {2{req_wdata_i[15:0]}};
         end
         2'b10:   misaligned = |req_addr_i[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   // Shift the addressed lane down to bit 0 before extending.
   always_comb begin
      lane = mem_rdata_i >> {addr_q, 3'b000};
      case (size_q)
         2'b00:   load_ext = {{24{signed_q & lane[7]}}, lane[7:0]};
         2'b01:   load_ext = {{16{signed_q & lane[15]}}, lane[15:0]};
         default: load_ext = mem_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= IDLE;
         wait_cnt    <= '0;
         we_q        <= 1'b0;
         size_q      <= '0;
         signed_q    <= 1'b0;
         addr_q      <= '0;
         rd_q        <= '0;
         req_ready_o <= 1'b1;
         mem_req_o   <= 1'b0;
         mem_we_o    <= 1'b0;
         mem_addr_o  <= '0;
         mem_be_o    <= '0;
         mem_wdata_o <= '0;
         rsp_valid_o <= 1'b0;
         rsp_data_o  <= '0;
         rsp_rd_o    <= '0;
         rsp_err_o   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid_i) begin
                  we_q        <= req_we_i;
                  size_q      <= req_size_i;
                  signed_q    <= req_signed_i;
                  addr_q      <= req_addr_i[1:0];
                  rd_q        <= req_rd_i;
                  req_ready_o <= 1'b0;
                  wait_cnt    <= '0;
                  if (misaligned) begin
                     state       <= RESP;
                     rsp_valid_o <= 1'b1;
                     rsp_data_o  <= '0;
                     rsp_rd_o    <= req_rd_i;
                     rsp_err_o   <= 2'b01;
                  end else begin
                     state       <= WAIT;
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= req_we_i;
                     mem_addr_o  <= {req_addr_i[31:2], 2'b00};
                     mem_be_o    <= be_next;
                     mem_wdata_o <= wdata_next;
                  end
               end
            end
            WAIT: begin
               if (mem_ack_i) begin
                  state       <= RESP;
                  mem_req_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_data_o  <= we_q ? '0 : load_ext;
                  rsp_rd_o    <= rd_q;
                  rsp_err_o   <= 2'b00;
               end else if (wait_cnt == LAST_WAIT) begin
                  state       <= RESP;
                  mem_req_o   <= 1'b0;
                  rsp_valid_o <= 1'b1;
                  rsp_data_o  <= '0;
                  rsp_rd_o    <= rd_q;
                  rsp_err_o   <= 2'b10;
               end else begin
                  wait_cnt <= wait_cnt + 8'd1;
               end
            end
            RESP: begin
               if (rsp_ready_i) begin
                  state       <= IDLE;
                  rsp_valid_o <= 1'b0;
                  req_ready_o <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, max cycles waiting for mem_ack_i before error response (1..255).
REQ-002 SHALL have port clk_i  input  1  single clock, all logic rising-edge.
REQ-003 SHALL have port rst_i  input  1  synchronous, active-high reset.
REQ-004 SHALL have port req_valid_i  input  1  pipeline access request valid.
REQ-005 SHALL have port req_ready_o  output  1  unit accepts request this cycle.
REQ-006 SHALL have port req_we_i  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_size_i  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-008 SHALL have port req_signed_i  input  1  load result sign-extended (1) or zero-extended (0).
REQ-009 SHALL have port req_addr_i  input  32  byte address.
REQ-010 SHALL have port req_wdata_i  input  32  store data, low bits significant.
REQ-011 SHALL have port req_rd_i  input  5  destination register tag.
REQ-012 SHALL have port mem_req_o  output  1  memory access strobe.
REQ-013 SHALL have port mem_we_o  output  1  memory write enable.
REQ-014 SHALL have port mem_addr_o  output  32  word address, bits [1:0] = 00.
REQ-015 SHALL have port mem_be_o  output  4  byte enables, bit n = byte lane n (little-endian).
REQ-016 SHALL have port mem_wdata_o  output  32  lane-replicated store data.
REQ-017 SHALL have port mem_ack_i  input  1  memory completion, one-cycle pulse.
REQ-018 SHALL have port mem_rdata_i  input  32  read word, valid with mem_ack_i.
REQ-019 SHALL have port rsp_valid_o  output  1  result valid.
REQ-020 SHALL have port rsp_ready_i  input  1  pipeline consumes result.
REQ-021 SHALL have port rsp_data_o  output  32  extended load data; 0 for stores and errors.
REQ-022 SHALL have port rsp_rd_o  output  5  tag of completed request.
REQ-023 SHALL have port rsp_err_o  output  2  00 ok, 01 misaligned/illegal size, 10 timeout.

Function
REQ-024 SHALL implement FSM states IDLE, WAIT, RESP; req_ready_o = 1 only in IDLE.
REQ-025 SHALL accept on req_valid_i & req_ready_o, registering we, size, signed, addr[1:0], wdata, rd.
REQ-026 SHALL flag misaligned: halfword with addr[0]=1, word with addr[1:0]!=00, size 11; such requests go IDLE->RESP with rsp_err_o=01, no mem_req_o.
REQ-027 SHALL otherwise go IDLE->WAIT, asserting mem_req_o/mem_we_o/mem_addr_o/mem_be_o/mem_wdata_o held stable from the cycle after acceptance until mem_ack_i.
REQ-028 SHALL drive mem_be_o: byte 0001<<addr[1:0]; halfword 0011<<addr[1:0]; word 1111.
REQ-029 SHALL drive mem_wdata_o: byte {4{wdata[7:0]}}; halfword {2{wdata[15:0]}}; word wdata.
REQ-030 SHALL in WAIT on mem_ack_i deassert mem_req_o next cycle, go RESP; load data = selected lane(s) of mem_rdata_i, extended to 32 bits per req_signed_i.
REQ-031 SHALL count WAIT cycles; after TIMEOUT cycles without ack, drop mem_req_o, go RESP with rsp_err_o=10, rsp_data_o=0.
REQ-032 SHALL hold rsp_valid_o=1 and all rsp outputs stable in RESP until rsp_ready_i; on rsp_ready_i return to IDLE next cycle.
REQ-033 SHALL ignore mem_ack_i outside WAIT.
REQ-034 SHALL give request-to-response latency of 1 cycle for misaligned, ack cycle +1 otherwise; one request outstanding max.

Reset
REQ-035 SHALL on rst_i=1 at a clock edge enter IDLE, clear counter, drive req_ready_o=1 (after reset deasserts), mem_req_o=0, mem_we_o=0, mem_addr_o=0, mem_be_o=0, mem_wdata_o=0, rsp_valid_o=0, rsp_data_o=0, rsp_rd_o=0, rsp_err_o=00.
REQ-036 SHALL on reset during WAIT or RESP abandon the access with no response; a later mem_ack_i is ignored.

Verification
REQ-037 SHALL verify signed byte load addr 0x103, mem_rdata 0xF0123456 -> rsp_data_o 0xFFFFFFF0, mem_be_o 1000, mem_addr_o 0x100.
REQ-038 SHALL verify unsigned halfword load addr 0x102, mem_rdata 0x8001ABCD -> rsp_data_o 0x00008001; signed -> 0xFFFF8001.
REQ-039 SHALL verify byte store addr 0x21, wdata 0x123456AB -> mem_be_o 0010, mem_wdata_o 0xABABABAB, mem_we_o 1, rsp_data_o 0.
REQ-040 SHALL verify word load addr 0x2 -> rsp_err_o 01 next cycle, mem_req_o never asserted.
REQ-041 SHALL verify TIMEOUT=4, no ack -> mem_req_o drops, rsp_err_o 10 after 4 WAIT cycles; rsp_ready_i held 0 for 3 cycles keeps outputs stable.
REQ-042 SHALL verify rst_i pulsed in WAIT -> all outputs reset values next cycle, late mem_ack_i produces no rsp_valid_o.
